// File: rtl/bpred.sv
// Direct-mapped BTB branch predictor: combinational lookup for the fetch PC, trained from execute.
// Define BPRED_STATS_EN to build the saturating update/mispredict counters.
module bpred #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcf,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_jmp,
  input  logic            upd_mispred,
  input  logic            clr,
  output logic [31:0]     stat_upd,
  output logic [31:0]     stat_mispred
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jmp_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             accept_s;
  logic             wr_s;
  logic [1:0]       ctr_d;
  logic [XLEN-1:0]  target_d;
  logic             jmp_d;
  logic             unused_s;

  assign lk_idx_s = pcf[IDX_W+1:2];
  assign lk_tag_s = pcf[XLEN-1:IDX_W+2];
  assign up_idx_s = upd_pc[IDX_W+1:2];
  assign up_tag_s = upd_pc[XLEN-1:IDX_W+2];
  assign accept_s = upd_en & ~clr;
  assign unused_s = ^{pcf[1:0], upd_pc[1:0]};

  // Fetch lookup; invalid entries are never consulted, so unreset tag/target storage is harmless.
  always_comb begin
    pred_hit    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
    pred_taken  = pred_hit && (jmp_q[lk_idx_s] || ctr_q[lk_idx_s][1]);
    if (pred_taken) begin
      pred_target = target_q[lk_idx_s];
    end else begin
      pred_target = pcf + {{(XLEN-3){1'b0}}, 3'b100};
    end
  end

  // Training: compute the new contents of the entry addressed by upd_pc.
  always_comb begin
    up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
    wr_s     = 1'b0;
    ctr_d    = ctr_q[up_idx_s];
    target_d = target_q[up_idx_s];
    jmp_d    = jmp_q[up_idx_s];
    if (accept_s) begin
      if (up_hit_s) begin
        wr_s = 1'b1;
        if (upd_jmp) begin
          ctr_d    = 2'b11;
          target_d = upd_target;
          jmp_d    = 1'b1;
        end else if (upd_taken) begin
          ctr_d    = ctr_inc(ctr_q[up_idx_s]);
          target_d = upd_target;
        end else begin
          ctr_d    = ctr_dec(ctr_q[up_idx_s]);
        end
      end else if (upd_taken) begin
        wr_s     = 1'b1;
        ctr_d    = upd_jmp ? 2'b11 : 2'b10;
        target_d = upd_target;
        jmp_d    = upd_jmp;
      end else begin
        wr_s = 1'b0;
      end
    end else begin
      wr_s = 1'b0;
    end
  end

  // Valid bits and counters: async reset, clr invalidates everything and wins over an update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_s) begin
      valid_q[up_idx_s] <= 1'b1;
      ctr_q[up_idx_s]   <= ctr_d;
    end
  end

  // Tag, target and jump-type storage.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      tag_q[up_idx_s]    <= up_tag_s;
      target_q[up_idx_s] <= target_d;
      jmp_q[up_idx_s]    <= jmp_d;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_upd_d;
  logic [31:0] stat_mis_q;
  logic [31:0] stat_mis_d;

  // Saturating statistics; clr zeroes them ahead of any same-edge increment.
  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (clr) begin
      stat_upd_d = 32'h0000_0000;
      stat_mis_d = 32'h0000_0000;
    end else if (upd_en) begin
      if (stat_upd_q != 32'hFFFF_FFFF) begin
        stat_upd_d = stat_upd_q + 32'd1;
      end else begin
        stat_upd_d = stat_upd_q;
      end
      if (upd_mispred && (stat_mis_q != 32'hFFFF_FFFF)) begin
        stat_mis_d = stat_mis_q + 32'd1;
      end else begin
        stat_mis_d = stat_mis_q;
      end
    end else begin
      stat_upd_d = stat_upd_q;
      stat_mis_d = stat_mis_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_upd_q <= 32'h0000_0000;
      stat_mis_q <= 32'h0000_0000;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_upd     = stat_upd_q;
  assign stat_mispred = stat_mis_q;
`else
  logic unused_mispred_s;
  assign unused_mispred_s = upd_mispred;
  assign stat_upd         = 32'h0000_0000;
  assign stat_mispred     = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_bpred.sv
// Self-checking bench for bpred: directed scenarios plus random traffic against a table model.
module tb_bpred;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_jmp;
  logic        upd_mispred;
  logic        clr;
  logic [31:0] stat_upd;
  logic [31:0] stat_mispred;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          m_v  [ENTRIES];
  logic [31:0] m_tg [ENTRIES];
  logic [31:0] m_tt [ENTRIES];
  int          m_c  [ENTRIES];
  bit          m_j  [ENTRIES];
  longint      m_su;
  longint      m_sm;

  bpred dut (
    .clk(clk), .rst(rst), .pcf(pcf),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_jmp(upd_jmp), .upd_mispred(upd_mispred), .clr(clr),
    .stat_upd(stat_upd), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 1'b0;
      m_c[i] = 1;
    end
    m_su = 0;
    m_sm = 0;
  endtask

  // What the table should become on one rising edge, given the inputs presented before it.
  task automatic model_edge();
    int i;
    if (!rst) begin
      model_reset();
    end else if (clr) begin
      for (int k = 0; k < ENTRIES; k++) m_v[k] = 1'b0;
      m_su = 0;
      m_sm = 0;
    end else if (upd_en) begin
      if (m_su < 64'hFFFF_FFFF) m_su++;
      if (upd_mispred && m_sm < 64'hFFFF_FFFF) m_sm++;
      i = midx(upd_pc);
      if (m_v[i] && m_tg[i] == mtag(upd_pc)) begin
        if (upd_jmp) begin
          m_c[i] = 3; m_tt[i] = upd_target; m_j[i] = 1'b1;
        end else if (upd_taken) begin
          m_c[i] = (m_c[i] < 3) ? m_c[i] + 1 : 3; m_tt[i] = upd_target;
        end else begin
          m_c[i] = (m_c[i] > 0) ? m_c[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_v[i] = 1'b1; m_tg[i] = mtag(upd_pc); m_tt[i] = upd_target;
        m_j[i] = upd_jmp; m_c[i] = upd_jmp ? 3 : 2;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Look up pc and compare the DUT against the model (and the stat counters).
  task automatic check(input string tag, input logic [31:0] pc);
    int          i;
    bit          e_hit;
    bit          e_tkn;
    logic [31:0] e_tgt;
    pcf = pc;
    #1;
    i     = midx(pc);
    e_hit = m_v[i] && (m_tg[i] == mtag(pc));
    e_tkn = e_hit && (m_j[i] || m_c[i] >= 2);
    e_tgt = e_tkn ? m_tt[i] : pc + 32'd4;
    cmp({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, e_hit});
    cmp({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, e_tkn});
    cmp({tag, ".target"}, pred_target, e_tgt);
`ifdef BPRED_STATS_EN
    cmp({tag, ".stat_upd"}, stat_upd, m_su[31:0]);
    cmp({tag, ".stat_mis"}, stat_mispred, m_sm[31:0]);
`else
    cmp({tag, ".stat_upd"}, stat_upd, 32'd0);
    cmp({tag, ".stat_mis"}, stat_mispred, 32'd0);
`endif
  endtask

  task automatic check_lit(input string tag, input logic [31:0] pc, input logic hit,
                           input logic tkn, input logic [31:0] tgt);
    pcf = pc;
    #1;
    cmp({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, hit});
    cmp({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tkn});
    cmp({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tgt,
                     input logic jmp, input logic mis);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tkn; upd_target = tgt;
    upd_jmp = jmp; upd_mispred = mis;
    tick();
    upd_en = 1'b0; upd_mispred = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; upd_en = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    upd_target = 32'd0; upd_jmp = 1'b0; upd_mispred = 1'b0; pcf = 32'h100;
    model_reset();
    #2;
    check_lit("in_reset", 32'h100, 1'b0, 1'b0, 32'h104);
    check("in_reset_m", 32'h100);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_lit("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    check_lit("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    check_lit("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
    check_lit("nt_once", 32'h100, 1'b1, 1'b0, 32'h104);

    repeat (4) upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    check_lit("sat_hi", 32'h100, 1'b1, 1'b1, 32'h80);
    repeat (3) upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    check("sat_lo", 32'h100);
    upd(32'h100, 1'b1, 32'h90, 1'b0, 1'b0);
    check_lit("from_00", 32'h100, 1'b1, 1'b0, 32'h104);

    upd(32'h200, 1'b1, 32'h300, 1'b0, 1'b0);
    check_lit("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    check_lit("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    upd(32'h40C, 1'b1, 32'h500, 1'b1, 1'b0);
    check_lit("jal", 32'h40C, 1'b1, 1'b1, 32'h500);

    clr = 1'b1;
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
    clr = 1'b0;
    check_lit("clr_upd", 32'h100, 1'b0, 1'b0, 32'h104);
    check("clr_upd_m", 32'h200);

    for (int k = 0; k < 5; k++) upd(32'h600 + 32'(k * 4), 1'(k % 2), 32'h700, 1'b0, 1'(k < 2));
    check("stats5", 32'h600);

    for (int k = 0; k < 400; k++) begin
      upd_en      = ($urandom_range(0, 2) != 0);
      upd_pc      = rand_pc();
      upd_jmp     = ($urandom_range(0, 4) == 0);
      upd_taken   = upd_jmp | 1'($urandom_range(0, 1));
      upd_target  = $urandom() & 32'hFFFF_FFFC;
      upd_mispred = 1'($urandom_range(0, 1));
      clr         = ($urandom_range(0, 63) == 0);
      check("rand", rand_pc());
      tick();
    end
    upd_en = 1'b0; clr = 1'b0; upd_mispred = 1'b0;
    check("rand_end", 32'h100);

    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
    #3;
    rst = 1'b0;
    model_reset();
    check_lit("async_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    check("async_rst_m", 32'h100);
    tick();
    rst = 1'b1;
    tick();
    check("after_rst", 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
